// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; master = source/consumer, slave = adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (one full-adder cell + carry flop), LSB first; SERIAL_ADDER_OVF_EN adds signed overflow.
// Latency: accept at edge E0, out_valid after edge E0+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: holds DONE with stable outputs while out_ready is low; in_ready only in IDLE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q, out_valid_q, busy_q;

    logic             s_bit, carry_d, last_bit;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        s_bit    = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_d  = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
        // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
        sum_d    = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_bit) begin
            ovf_q <= carry_q ^ carry_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_q      <= bus.a;
                        opb_q      <= bus.b;
                        carry_q    <= bus.cin;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    carry_q <= carry_d;
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    sum_q   <= sum_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        cout_q      <= carry_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule
